// File: rtl/ed25519_host_link.sv
// Host-side link to the ed25519 core: serialises one scalar-multiplication job
// into 12 stream words, then gathers the 8 result words into xg/yg.
module ed25519_host_link #(
    parameter int DATA_W  = 64,
    parameter int COORD_W = 255,
    parameter int TIMEOUT = 1048576
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_scalar,
    input  logic [COORD_W-1:0] i_xp,
    input  logic [COORD_W-1:0] i_yp,
    output logic               o_busy,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [DATA_W-1:0]  o_tx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    input  logic [DATA_W-1:0]  i_rx_data,
    output logic [COORD_W-1:0] o_xg,
    output logic [COORD_W-1:0] o_yg,
    output logic               o_done,
    output logic               o_timeout
);

    typedef enum logic [2:0] {IDLE, SEND, RECV, DONE, ABORT} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] m_q, m_d, xp_q, xp_d, yp_q, yp_d;
    logic [COORD_W-1:0] xsh_q, xsh_d, ysh_q, ysh_d;
    logic [COORD_W-1:0] xg_q, xg_d, yg_q, yg_d;
    logic [1:0]         which_q, which_d, idx_q, idx_d;
    logic [2:0]         rx_cnt_q, rx_cnt_d;
    logic [31:0]        to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d, rx_ready_q, rx_ready_d;
    logic               busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic               tx_hs, rx_hs;
    logic [COORD_W-1:0] next_op;

    // MSB-first split; the top word carries only bits 254..192, so its bit 63 is 0
    function automatic logic [DATA_W-1:0] word_of(input logic [COORD_W-1:0] v,
                                                  input logic [1:0] i);
        logic [DATA_W-1:0] w;
        case (i)
            2'd0:    w = {1'b0, v[COORD_W-1:3*DATA_W]};
            2'd1:    w = v[3*DATA_W-1:2*DATA_W];
            2'd2:    w = v[2*DATA_W-1:DATA_W];
            default: w = v[DATA_W-1:0];
        endcase
        return w;
    endfunction

    assign tx_hs = tx_valid_q & i_tx_ready;
    assign rx_hs = rx_ready_q & i_rx_valid;

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        xp_d       = xp_q;
        yp_d       = yp_q;
        xsh_d      = xsh_q;
        ysh_d      = ysh_q;
        xg_d       = xg_q;
        yg_d       = yg_q;
        which_d    = which_q;
        idx_d      = idx_q;
        rx_cnt_d   = rx_cnt_q;
        to_cnt_d   = to_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rx_ready_d = rx_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        next_op    = m_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    m_d        = i_scalar;
                    xp_d       = i_xp;
                    yp_d       = i_yp;
                    which_d    = 2'd0;
                    idx_d      = 2'd0;
                    tx_data_d  = word_of(i_scalar, 2'd0);
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_hs) begin
                    if (which_q == 2'd2 && idx_q == 2'd3) begin
                        which_d    = 2'd0;
                        idx_d      = 2'd0;
                        tx_valid_d = 1'b0;
                        rx_ready_d = 1'b1;
                        rx_cnt_d   = 3'd0;
                        to_cnt_d   = 32'd0;
                        state_d    = RECV;
                    end else begin
                        if (idx_q == 2'd3) begin
                            idx_d   = 2'd0;
                            which_d = which_q + 2'd1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                        case (which_d)
                            2'd0:    next_op = m_q;
                            2'd1:    next_op = xp_q;
                            default: next_op = yp_q;
                        endcase
                        tx_data_d = word_of(next_op, idx_d);
                    end
                end
            end
            RECV: begin
                if (rx_hs) begin
                    // Four 64-bit shifts into 255 bits drop bit 63 of w0 for free
                    if (!rx_cnt_q[2]) begin
                        xsh_d = {xsh_q[COORD_W-DATA_W-1:0], i_rx_data};
                    end else begin
                        ysh_d = {ysh_q[COORD_W-DATA_W-1:0], i_rx_data};
                    end
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    to_cnt_d = 32'd0;
                    if (rx_cnt_q == 3'd7) begin
                        xg_d       = xsh_q;
                        yg_d       = {ysh_q[COORD_W-DATA_W-1:0], i_rx_data};
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        rx_ready_d = 1'b0;
                        state_d    = DONE;
                    end
                end else if (TIMEOUT != 0) begin
                    if (to_cnt_q == TO_LAST) begin
                        timeout_d  = 1'b1;
                        busy_d     = 1'b0;
                        rx_ready_d = 1'b0;
                        state_d    = ABORT;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            m_q        <= '0;
            xp_q       <= '0;
            yp_q       <= '0;
            xsh_q      <= '0;
            ysh_q      <= '0;
            xg_q       <= '0;
            yg_q       <= '0;
            which_q    <= '0;
            idx_q      <= '0;
            rx_cnt_q   <= '0;
            to_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            xp_q       <= xp_d;
            yp_q       <= yp_d;
            xsh_q      <= xsh_d;
            ysh_q      <= ysh_d;
            xg_q       <= xg_d;
            yg_q       <= yg_d;
            which_q    <= which_d;
            idx_q      <= idx_d;
            rx_cnt_q   <= rx_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_rx_ready = rx_ready_q;
    assign o_xg       = xg_q;
    assign o_yg       = yg_q;
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;

endmodule
